lsu_timed: RTL

- Parametrised per-thread load-store unit, next generation of the per-thread LSU.
- One instance per thread per core. Executes LDR and STR against the data-memory valid/ready channel.
- Adds configurable address and data widths, a base+offset effective address and a transaction latched at issue.
- Adds a watchdog timeout with an error state, and detection of illegal simultaneous read and write decode.

---
 rtl/lsu_timed.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lsu_timed.sv
// lsu_timed: per-thread load-store unit with base+offset addressing, latched transactions,
// a watchdog timeout and illegal read+write decode detection.
package lsu_timed_pkg;
   typedef enum logic [2:0] {
      CORE_IDLE, CORE_FETCH, CORE_DECODE, CORE_REQUEST,
      CORE_WAIT, CORE_EXECUTE, CORE_UPDATE, CORE_DONE
   } corestate_t;
endpackage

module lsu_timed
   import lsu_timed_pkg::*;
#(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter int IMM_BITS       = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  corestate_t           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [ADDR_BITS-1:0] rs,
   input  logic [IMM_BITS-1:0]  imm,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [2:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);
   localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERROR
   } state_t;

   state_t               state_q, state_d;
   logic                 op_wr_q, op_wr_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 rv_q, rv_d, wv_q, wv_d, err_q, err_d;
   logic [ADDR_BITS-1:0] ra_q, ra_d, wa_q, wa_d, ea;
   logic [DATA_BITS-1:0] wd_q, wd_d, out_q, out_d;
   logic                 ready;

   assign ea    = rs + ADDR_BITS'($signed(imm));
   assign ready = op_wr_q ? mem_write_ready : mem_read_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_wr_q <= 1'b0;
         timer_q <= '0;
         rv_q    <= 1'b0;
         wv_q    <= 1'b0;
         err_q   <= 1'b0;
         ra_q    <= '0;
         wa_q    <= '0;
         wd_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         op_wr_q <= op_wr_d;
         timer_q <= timer_d;
         rv_q    <= rv_d;
         wv_q    <= wv_d;
         err_q   <= err_d;
         ra_q    <= ra_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_wr_d = op_wr_q;
      timer_d = timer_q;
      rv_d    = rv_q;
      wv_d    = wv_q;
      err_d   = err_q;
      ra_d    = ra_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      out_d   = out_q;
      if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (core_state == CORE_REQUEST) begin
                  if (decoded_mem_read_enable && decoded_mem_write_enable) begin
                     err_d   = 1'b1;
                     state_d = S_ERROR;
                  end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
                     op_wr_d = decoded_mem_write_enable;
                     state_d = S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (op_wr_q) begin
                  wv_d = 1'b1;
                  wa_d = ea;
                  wd_d = rt;
               end else begin
                  rv_d = 1'b1;
                  ra_d = ea;
               end
               timer_d = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               // ready has priority over a timeout expiring in the same cycle
               if (ready) begin
                  rv_d    = 1'b0;
                  wv_d    = 1'b0;
                  out_d   = op_wr_q ? out_q : mem_read_data;
                  state_d = S_DONE;
               end else if (TO_EN && timer_q == T_LAST) begin
                  rv_d    = 1'b0;
                  wv_d    = 1'b0;
                  err_d   = 1'b1;
                  state_d = S_ERROR;
               end else begin
                  timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
               end
            end
            S_DONE: state_d = (core_state == CORE_UPDATE) ? S_IDLE : S_DONE;
            S_ERROR: begin
               if (core_state == CORE_UPDATE) begin
                  err_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign mem_read_valid    = rv_q;
   assign mem_read_address  = ra_q;
   assign mem_write_valid   = wv_q;
   assign mem_write_address = wa_q;
   assign mem_write_data    = wd_q;
   assign lsu_state         = state_q;
   assign lsu_out           = out_q;
   assign lsu_error         = err_q;
endmodule
